// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings and the branch controller's FSM state type.
package rv32i_pkg;

   localparam logic [2:0] VT_BRANCH = 3'b011;
   localparam logic [2:0] VT_JUMP   = 3'b100;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // 010/011 are not branch comparisons; the comparator result is meaningless there.
   function automatic logic f3_is_branch(input logic [2:0] f3);
      return !((f3 == 3'b010) || (f3 == 3'b011));
   endfunction

endpackage

// File: rtl/Comparator.sv
// Shared branch comparator: ld is the taken condition for the selected compare type.
module Comparator
   import rv32i_pkg::*;
(
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [2:0]  cmp_type,
   output logic        ld
);

   always_comb begin
      ld = 1'b0;
      case (cmp_type)
         F3_BEQ:  ld = (in_a == in_b);
         F3_BNE:  ld = (in_a != in_b);
         F3_BLT:  ld = ($signed(in_a) <  $signed(in_b));
         F3_BGE:  ld = ($signed(in_a) >= $signed(in_b));
         F3_BLTU: ld = (in_a <  in_b);
         F3_BGEU: ld = (in_a >= in_b);
         default: ld = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: resolves branches/jumps, issues a fetch redirect,
// then holds a fixed-length flush window. Also keeps branch statistics.
//
// state    | meaning
// ST_RUN   | accepting one instruction per cycle, in_ready high
// ST_FLUSH | flush window after a redirect, in_ready low, flush high
module branch_ctrl
   import rv32i_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      pc,
   input  logic [31:0]      rs1_val,
   input  logic [31:0]      rs2_val,
   input  logic [31:0]      imm,
   input  logic [2:0]       funct3,
   input  logic [2:0]       val_type,
   input  logic             is_jalr,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             link_valid,
   output logic [31:0]      link_data,
   output logic             flush,
   output logic             misalign_err,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   state_t      state, state_next;
   logic [2:0]  fl_cnt, fl_cnt_next;

   logic        accept;
   logic        is_branch;
   logic        is_jump;
   logic        cmp_ld;
   logic        taken;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        redirect;
   logic        misalign;

   Comparator u_cmp (
      .in_a     (rs1_val),
      .in_b     (rs2_val),
      .cmp_type (funct3),
      .ld       (cmp_ld)
   );

   assign in_ready  = (state == ST_RUN);
   assign accept    = in_valid & in_ready;
   assign is_branch = (val_type == VT_BRANCH);
   assign is_jump   = (val_type == VT_JUMP);

   assign taken     = accept & ((is_branch & f3_is_branch(funct3) & cmp_ld) | is_jump);
   assign jalr_sum  = rs1_val + imm;
   assign target    = (is_jump & is_jalr) ? {jalr_sum[31:1], 1'b0} : (pc + imm);

   // A target with bit1 set would fault in fetch, so it is reported instead of redirected.
   assign redirect  = taken & ~target[1];
   assign misalign  = taken &  target[1];

   always_comb begin
      state_next  = state;
      fl_cnt_next = fl_cnt;
      case (state)
         ST_RUN: begin
            if (redirect) begin
               state_next  = ST_FLUSH;
               fl_cnt_next = 3'(FLUSH_CYCLES - 1);
            end
         end
         ST_FLUSH: begin
            if (fl_cnt == 3'd0) begin
               state_next = ST_RUN;
            end else begin
               fl_cnt_next = fl_cnt - 3'd1;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RUN;
         fl_cnt <= 3'd0;
      end else begin
         state  <= state_next;
         fl_cnt <= fl_cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         link_valid     <= 1'b0;
         link_data      <= 32'd0;
         flush          <= 1'b0;
         misalign_err   <= 1'b0;
         branch_cnt     <= '0;
         taken_cnt      <= '0;
      end else begin
         redirect_valid <= redirect;
         misalign_err   <= misalign;
         link_valid     <= accept & is_jump;
         flush          <= (state_next == ST_FLUSH);
         if (taken) begin
            redirect_pc <= target;
         end
         if (accept & is_jump) begin
            link_data <= pc + 32'd4;
         end
         if (accept & is_branch) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (redirect) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: each accepted instruction pushes its expected
// pulse/hold values, which are popped and compared one cycle later.
module tb_branch_ctrl;
   import rv32i_pkg::*;

   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      pc;
   logic [31:0]      rs1_val;
   logic [31:0]      rs2_val;
   logic [31:0]      imm;
   logic [2:0]       funct3;
   logic [2:0]       val_type;
   logic             is_jalr;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             link_valid;
   logic [31:0]      link_data;
   logic             flush;
   logic             misalign_err;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] taken_cnt;

   always #5 clk = ~clk;

   branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .pc             (pc),
      .rs1_val        (rs1_val),
      .rs2_val        (rs2_val),
      .imm            (imm),
      .funct3         (funct3),
      .val_type       (val_type),
      .is_jalr        (is_jalr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .link_valid     (link_valid),
      .link_data      (link_data),
      .flush          (flush),
      .misalign_err   (misalign_err),
      .branch_cnt     (branch_cnt),
      .taken_cnt      (taken_cnt)
   );

   typedef struct packed {
      logic        rv;
      logic [31:0] rpc;
      logic        lv;
      logic [31:0] ld;
      logic        me;
   } exp_t;

   exp_t             sb[$];
   int               vectors     = 0;
   int               miscompares = 0;
   logic [31:0]      m_rpc;
   logic [31:0]      m_ld;
   logic [CNT_W-1:0] m_branch;
   logic [CNT_W-1:0] m_taken;
   logic [31:0]      opv[4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

   function automatic exp_t model(input logic [31:0] p, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] im,
                                  input logic [2:0] f3, input logic [2:0] vt,
                                  input logic jr);
      exp_t        e;
      logic        tk;
      logic [31:0] tgt;
      e.rv  = 1'b0;
      e.rpc = m_rpc;
      e.lv  = 1'b0;
      e.ld  = m_ld;
      e.me  = 1'b0;
      tk    = 1'b0;
      if (vt == 3'b011) begin
         case (f3)
            3'b000:  tk = (r1 == r2);
            3'b001:  tk = (r1 != r2);
            3'b100:  tk = ($signed(r1) <  $signed(r2));
            3'b101:  tk = ($signed(r1) >= $signed(r2));
            3'b110:  tk = (r1 <  r2);
            3'b111:  tk = (r1 >= r2);
            default: tk = 1'b0;
         endcase
      end else if (vt == 3'b100) begin
         tk = 1'b1;
      end
      tgt = (vt == 3'b100 && jr) ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
      if (tk) begin
         e.rpc = tgt;
         if (tgt[1]) e.me = 1'b1;
         else        e.rv = 1'b1;
      end
      if (vt == 3'b100) begin
         e.lv = 1'b1;
         e.ld = p + 32'd4;
      end
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_rpc    = '0;
      m_ld     = '0;
      m_branch = '0;
      m_taken  = '0;
      sb.delete();
   endtask

   // Drive one instruction for one cycle and push the outcome the bench expects.
   task automatic send(input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [2:0] f3, input logic [2:0] vt,
                       input logic jr, input logic expect_accept);
      exp_t e;
      pc       = p;
      rs1_val  = r1;
      rs2_val  = r2;
      imm      = im;
      funct3   = f3;
      val_type = vt;
      is_jalr  = jr;
      in_valid = 1'b1;
      e = '{rv: 1'b0, rpc: m_rpc, lv: 1'b0, ld: m_ld, me: 1'b0};
      if (expect_accept) begin
         e     = model(p, r1, r2, im, f3, vt, jr);
         m_rpc = e.rpc;
         m_ld  = e.ld;
         if (vt == 3'b011) m_branch = m_branch + 1;
         if (e.rv)         m_taken  = m_taken + 1;
      end
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int k = 0; k < 16 && !in_ready; k++) tick();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_timeout in_ready=%0b want 1", tag, in_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      vectors++;
      if ({in_ready, flush, redirect_valid, link_valid, misalign_err} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 10000",
                  {in_ready, flush, redirect_valid, link_valid, misalign_err});
      end
      vectors++;
      if ({redirect_pc, link_data, branch_cnt, taken_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_data rpc=%h ld=%h bc=%0d tc=%0d want all 0",
                  redirect_pc, link_data, branch_cnt, taken_cnt);
      end
   endtask

   task automatic test_beq;
      exp_t e;
      send(32'h100, 32'd5, 32'd5, 32'h20, F3_BEQ, VT_BRANCH, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
         miscompares++;
         $display("FAIL beq_pulse got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
      end
      vectors++;
      if ({branch_cnt, taken_cnt} !== {m_branch, m_taken}) begin
         miscompares++;
         $display("FAIL beq_cnt got bc=%0d tc=%0d want bc=%0d tc=%0d",
                  branch_cnt, taken_cnt, m_branch, m_taken);
      end
      for (int k = 0; k < FLUSH_CYCLES; k++) begin
         vectors++;
         if ({flush, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL beq_flush_window cycle %0d got flush=%0b ready=%0b want 1 0",
                     k, flush, in_ready);
         end
         tick();
      end
      vectors++;
      if ({flush, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL beq_flush_end got flush=%0b ready=%0b want 0 1", flush, in_ready);
      end
   endtask

   task automatic test_blt_bltu;
      exp_t e;
      send(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, F3_BLT, VT_BRANCH, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
         miscompares++;
         $display("FAIL blt_pulse got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
      end
      wait_ready("blt");
      send(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, F3_BLTU, VT_BRANCH, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready} !== {e, 1'b1}) begin
         miscompares++;
         $display("FAIL bltu_pulse got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready}, {e, 1'b1});
      end
      vectors++;
      if ({branch_cnt, taken_cnt} !== {m_branch, m_taken}) begin
         miscompares++;
         $display("FAIL bltu_cnt got bc=%0d tc=%0d want bc=%0d tc=%0d",
                  branch_cnt, taken_cnt, m_branch, m_taken);
      end
   endtask

   task automatic test_jalr_misalign;
      exp_t e;
      send(32'h40, 32'h203, 32'h0, 32'h0, 3'b000, VT_JUMP, 1'b1, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
         miscompares++;
         $display("FAIL jalr_misalign got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
      end
      vectors++;
      if ({flush, in_ready, taken_cnt} !== {2'b01, m_taken}) begin
         miscompares++;
         $display("FAIL jalr_no_flush got flush=%0b ready=%0b tc=%0d want 0 1 %0d",
                  flush, in_ready, taken_cnt, m_taken);
      end
   endtask

   task automatic test_back_to_back;
      exp_t       e;
      logic [2:0] vts[3] = '{3'b000, 3'b010, 3'b111};
      for (int i = 0; i < 3; i++) begin
         send(32'h500 + 32'(4 * i), 32'd7, 32'd7, 32'h10, F3_BEQ, vts[i], 1'b0, 1'b1);
         e = sb.pop_front();
         vectors++;
         if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready} !== {e, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_nonctrl %0d got %h want %h", i,
                     {redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready}, {e, 1'b1});
         end
      end
      send(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 3'b000, VT_JUMP, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
         miscompares++;
         $display("FAIL jal_wrap got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
      end
      // Offered during the flush window: must be ignored entirely.
      send(32'h800, 32'd1, 32'd1, 32'h40, F3_BEQ, VT_BRANCH, 1'b0, 1'b0);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
         miscompares++;
         $display("FAIL flush_ignore got %h want %h",
                  {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
      end
      vectors++;
      if ({branch_cnt, taken_cnt} !== {m_branch, m_taken}) begin
         miscompares++;
         $display("FAIL flush_ignore_cnt got bc=%0d tc=%0d want bc=%0d tc=%0d",
                  branch_cnt, taken_cnt, m_branch, m_taken);
      end
      wait_ready("b2b");
   endtask

   task automatic test_funct3_masked;
      exp_t       e;
      logic [2:0] f3s[2] = '{3'b010, 3'b011};
      for (int i = 0; i < 2; i++) begin
         send(32'h600, 32'd9, 32'd9, 32'h10, f3s[i], VT_BRANCH, 1'b0, 1'b1);
         e = sb.pop_front();
         vectors++;
         if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready} !== {e, 1'b1}) begin
            miscompares++;
            $display("FAIL f3_masked %0d got %h want %h", i,
                     {redirect_valid, redirect_pc, link_valid, link_data, misalign_err, in_ready}, {e, 1'b1});
         end
      end
   endtask

   task automatic test_random;
      exp_t        e;
      logic [2:0]  vt;
      logic [31:0] im;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0:       vt = VT_BRANCH;
            1:       vt = VT_JUMP;
            default: vt = 3'b000;
         endcase
         im = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 3) == 0) im = im + 32'd2;
         send(32'($urandom) & 32'hFFFF_FFFC, opv[$urandom_range(0, 3)], opv[$urandom_range(0, 3)],
              im, 3'($urandom_range(0, 7)), vt, 1'($urandom_range(0, 1)), 1'b1);
         e = sb.pop_front();
         vectors++;
         if ({redirect_valid, redirect_pc, link_valid, link_data, misalign_err} !== e) begin
            miscompares++;
            $display("FAIL rand %0d got %h want %h", i,
                     {redirect_valid, redirect_pc, link_valid, link_data, misalign_err}, e);
         end
         vectors++;
         if ({branch_cnt, taken_cnt} !== {m_branch, m_taken}) begin
            miscompares++;
            $display("FAIL rand_cnt %0d got bc=%0d tc=%0d want bc=%0d tc=%0d",
                     i, branch_cnt, taken_cnt, m_branch, m_taken);
         end
         wait_ready("rand");
      end
   endtask

   task automatic test_reset_mid_flush;
      exp_t e;
      send(32'h700, 32'd3, 32'd3, 32'h40, F3_BEQ, VT_BRANCH, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({redirect_valid, flush} !== 2'b11) begin
         miscompares++;
         $display("FAIL rstflush_pre got rv=%0b flush=%0b want 1 1", redirect_valid, flush);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      vectors++;
      if ({flush, in_ready, redirect_valid, branch_cnt, taken_cnt} !== {3'b010, {(2 * CNT_W){1'b0}}}) begin
         miscompares++;
         $display("FAIL rstflush_post got flush=%0b ready=%0b rv=%0b bc=%0d tc=%0d want 0 1 0 0 0",
                  flush, in_ready, redirect_valid, branch_cnt, taken_cnt);
      end
      tick();
      vectors++;
      if ({flush, in_ready, redirect_valid, misalign_err, link_valid} !== 5'b01000) begin
         miscompares++;
         $display("FAIL rstflush_after got %b want 01000",
                  {flush, in_ready, redirect_valid, misalign_err, link_valid});
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      pc       = '0;
      rs1_val  = '0;
      rs2_val  = '0;
      imm      = '0;
      funct3   = '0;
      val_type = '0;
      is_jalr  = 1'b0;
      model_reset();
      tick();
      test_reset();
      test_beq();
      test_blt_bltu();
      test_jalr_misalign();
      test_back_to_back();
      test_funct3_masked();
      test_random();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
